hpi_responder: RTL and testbench

HPI_RESPONDER -- requirements
Module: hpi_responder

---
 rtl/hpi_pkg.sv | 13 +
 rtl/hpi_resp_ram.sv | 18 +
 rtl/hpi_responder.sv | 121 ++++++++++++
 tb/tb_hpi_responder.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/hpi_pkg.sv
// hpi_pkg: shared register-select codes, STATUS bit positions and pointer step for the HPI responder
package hpi_pkg;
   typedef enum logic [1:0] {
      REG_DATA = 2'd0,
      REG_MBX  = 2'd1,
      REG_ADDR = 2'd2,
      REG_STAT = 2'd3
   } reg_sel_t;
   localparam int ST_RX_VALID = 0;
   localparam int ST_TX_FULL = 1;
   localparam int ST_ERR = 2;
   localparam logic [15:0] PTR_INC = 16'd2;
endpackage

// File: rtl/hpi_resp_ram.sv
// hpi_resp_ram: single-port synchronous RAM, WORDS x 16, registered read
module hpi_resp_ram #(
   parameter int WORDS = 256,
   localparam int AW = $clog2(WORDS)
) (
   input  logic          clk,
   input  logic          we,
   input  logic          re,
   input  logic [AW-1:0] addr,
   input  logic [15:0]   wdata,
   output logic [15:0]   q
);
   logic [15:0] mem [WORDS];
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wdata;
      if (re) q <= mem[addr];
   end
endmodule

// File: rtl/hpi_responder.sv
// hpi_responder: HPI slave with pointer-addressed RAM and mailboxes (mailboxes need HPI_RESPONDER_MAILBOX_EN)
module hpi_responder
   import hpi_pkg::*;
#(
   parameter int MEM_WORDS = 256
) (
   input  logic        Clk,
   input  logic        Reset,
   inout  wire  [15:0] OTG_DATA,
   input  logic [1:0]  OTG_ADDR,
   input  logic        OTG_CS_N,
   input  logic        OTG_RD_N,
   input  logic        OTG_WR_N,
   input  logic        OTG_RST_N,
   output logic        OTG_INT,
   output logic [15:0] mbx_rx_data,
   output logic        mbx_rx_valid,
   input  logic        mbx_rx_ack,
   input  logic [15:0] mbx_tx_data,
   input  logic        mbx_tx_valid,
   output logic        mbx_tx_ready
);
   localparam int AW = $clog2(MEM_WORDS);
   reg_sel_t s_addr, d_addr;
   logic s_cs_n, s_rd_n, s_wr_n, s_rst_n, d_cs_n, d_rd_n, d_wr_n;
   logic [15:0] s_data, d_data;
   logic rst, blocked, perr, rd_go, wr_go, ram_we, ram_re, rd_mbx, wr_mbx, rd_stat, mbx_err;
   logic err, rd_ram, rx_valid, tx_full;
   logic [15:0] ptr, rdata_q, rdata, ram_q, rsel, stat, tx_data;
   always_ff @(posedge Clk) begin
      s_addr  <= reg_sel_t'(OTG_ADDR);
      s_cs_n  <= OTG_CS_N;
      s_rd_n  <= OTG_RD_N;
      s_wr_n  <= OTG_WR_N;
      s_data  <= OTG_DATA;
      s_rst_n <= OTG_RST_N;
      d_addr  <= s_addr;
      d_cs_n  <= s_cs_n;
      d_rd_n  <= s_rd_n;
      d_wr_n  <= s_wr_n;
      d_data  <= s_data;
   end
   assign rst = Reset | ~s_rst_n;
   assign perr = ~s_cs_n & ~s_rd_n & ~s_wr_n;
   // blocked swallows any strobe that overlapped a reset or a protocol error
   assign rd_go = ~rst & ~blocked & ~s_cs_n & ~s_rd_n & d_rd_n & s_wr_n;
   assign wr_go = ~rst & ~blocked & ~d_cs_n & ~d_wr_n & s_wr_n;
   assign ram_we = wr_go & (d_addr == REG_DATA);
   assign ram_re = rd_go & (s_addr == REG_DATA);
   assign wr_mbx = wr_go & (d_addr == REG_MBX);
   assign rd_mbx = rd_go & (s_addr == REG_MBX);
   assign rd_stat = rd_go & (s_addr == REG_STAT);
   always_comb begin
      stat = '0;
      stat[ST_RX_VALID] = rx_valid;
      stat[ST_TX_FULL] = tx_full;
      stat[ST_ERR] = err;
   end
   assign rsel = (s_addr == REG_MBX) ? tx_data : (s_addr == REG_ADDR) ? ptr : (s_addr == REG_STAT) ? stat : '0;
   assign rdata = rd_ram ? ram_q : rdata_q;
   assign OTG_DATA = (~OTG_CS_N & ~OTG_RD_N & OTG_WR_N & ~Reset & OTG_RST_N) ? rdata : 16'bz;
   always_ff @(posedge Clk) begin
      if (rst) begin
         ptr     <= '0;
         err     <= 1'b0;
         rdata_q <= '0;
         rd_ram  <= 1'b0;
         blocked <= 1'b1;
      end else begin
         blocked <= perr | (blocked & ~(s_rd_n & s_wr_n));
         err     <= perr | mbx_err | (err & ~rd_stat);
         if (wr_go && d_addr == REG_ADDR) ptr <= d_data;
         else if (ram_we | ram_re) ptr <= ptr + PTR_INC;
         if (rd_go) begin
            rd_ram  <= s_addr == REG_DATA;
            rdata_q <= rsel;
         end
      end
   end
   hpi_resp_ram #(.WORDS(MEM_WORDS)) u_ram (
      .clk(Clk),
      .we(ram_we),
      .re(ram_re),
      .addr(ptr[AW:1]),
      .wdata(d_data),
      .q(ram_q)
   );
`ifdef HPI_RESPONDER_MAILBOX_EN
   assign mbx_err = wr_mbx & rx_valid & ~mbx_rx_ack;
   always_ff @(posedge Clk) begin
      if (rst) begin
         mbx_rx_data <= '0;
         rx_valid    <= 1'b0;
         tx_data     <= '0;
         tx_full     <= 1'b0;
      end else begin
         if (wr_mbx && (!rx_valid || mbx_rx_ack)) begin
            mbx_rx_data <= d_data;
            rx_valid    <= 1'b1;
         end else if (mbx_rx_ack) rx_valid <= 1'b0;
         // a local load beats a same-cycle host drain
         if (mbx_tx_valid && !tx_full) begin
            tx_data <= mbx_tx_data;
            tx_full <= 1'b1;
         end else if (rd_mbx) tx_full <= 1'b0;
      end
   end
   assign mbx_tx_ready = ~tx_full;
`else
   logic unused_mbx;
   assign unused_mbx = ^{mbx_rx_ack, mbx_tx_data, mbx_tx_valid, wr_mbx, rd_mbx};
   assign mbx_err = 1'b0;
   assign mbx_rx_data = '0;
   assign rx_valid = 1'b0;
   assign tx_data = '0;
   assign tx_full = 1'b0;
   assign mbx_tx_ready = 1'b0;
`endif
   assign mbx_rx_valid = rx_valid;
   assign OTG_INT = tx_full;
endmodule

// File: tb/tb_hpi_responder.sv
// tb_hpi_responder: directed HPI host transactions with hand-computed expectations
module tb_hpi_responder;
   logic clk = 1'b0, rst = 1'b1;
   logic [1:0] otg_addr = 2'd0;
   logic cs_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1, otg_rst_n = 1'b1;
   logic [15:0] drv = '0;
   logic drv_en = 1'b0;
   wire [15:0] otg_data;
   logic otg_int, rx_valid, rx_ack = 1'b0, tx_valid = 1'b0, tx_ready;
   logic [15:0] rx_data, tx_data = '0, rd;
   int n_vec = 0, n_err = 0;
   assign otg_data = drv_en ? drv : 16'bz;
   always #5 clk = ~clk;
   hpi_responder #(.MEM_WORDS(256)) dut (
      .Clk(clk),
      .Reset(rst),
      .OTG_DATA(otg_data),
      .OTG_ADDR(otg_addr),
      .OTG_CS_N(cs_n),
      .OTG_RD_N(rd_n),
      .OTG_WR_N(wr_n),
      .OTG_RST_N(otg_rst_n),
      .OTG_INT(otg_int),
      .mbx_rx_data(rx_data),
      .mbx_rx_valid(rx_valid),
      .mbx_rx_ack(rx_ack),
      .mbx_tx_data(tx_data),
      .mbx_tx_valid(tx_valid),
      .mbx_tx_ready(tx_ready)
   );
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic host_write(input logic [1:0] a, input logic [15:0] d);
      otg_addr = a;
      drv = d;
      drv_en = 1'b1;
      cs_n = 1'b0;
      wr_n = 1'b0;
      tick(3);
      wr_n = 1'b1;
      cs_n = 1'b1;
      tick(3);
      drv_en = 1'b0;
   endtask
   task automatic host_read(input logic [1:0] a, output logic [15:0] d);
      otg_addr = a;
      cs_n = 1'b0;
      rd_n = 1'b0;
      tick(4);
      d = otg_data;
      rd_n = 1'b1;
      cs_n = 1'b1;
      tick(2);
   endtask
   initial begin
      tick(3);
      rst = 1'b0;
      tick(2);
      check("rst_int", {15'b0, otg_int}, 16'h0);
      check("rst_rx_valid", {15'b0, rx_valid}, 16'h0);
`ifdef HPI_RESPONDER_MAILBOX_EN
      check("rst_tx_ready", {15'b0, tx_ready}, 16'h1);
`else
      check("rst_tx_ready", {15'b0, tx_ready}, 16'h0);
`endif
      host_read(2'd2, rd); check("rst_ptr", rd, 16'h0000);
      host_read(2'd3, rd); check("rst_status", rd, 16'h0000);
      host_write(2'd2, 16'h0010);
      host_write(2'd0, 16'hAAAA);
      host_write(2'd0, 16'h5555);
      host_write(2'd2, 16'h0010);
      host_read(2'd0, rd); check("rd_aaaa", rd, 16'hAAAA);
      host_read(2'd0, rd); check("rd_5555", rd, 16'h5555);
      host_read(2'd2, rd); check("ptr_0014", rd, 16'h0014);
      host_write(2'd2, 16'h01FE);
      host_write(2'd0, 16'h1111);
      host_write(2'd0, 16'h2222);
      host_read(2'd2, rd); check("ptr_0202", rd, 16'h0202);
      host_write(2'd2, 16'h0000);
      host_read(2'd0, rd); check("wrap_word0", rd, 16'h2222);
      host_write(2'd2, 16'h01FE);
      host_read(2'd0, rd); check("word255", rd, 16'h1111);
      host_write(2'd2, 16'h0020);
      host_write(2'd0, 16'h7777);
      host_write(2'd2, 16'h0020);
      otg_addr = 2'd0;
      drv = 16'h9999;
      drv_en = 1'b1;
      cs_n = 1'b0;
      rd_n = 1'b0;
      wr_n = 1'b0;
      tick(3);
      rd_n = 1'b1;
      wr_n = 1'b1;
      cs_n = 1'b1;
      tick(3);
      drv_en = 1'b0;
      host_read(2'd2, rd); check("perr_ptr", rd, 16'h0020);
      host_read(2'd3, rd); check("perr_status", rd, 16'h0004);
      host_read(2'd3, rd); check("err_cleared", rd, 16'h0000);
      host_read(2'd0, rd); check("perr_ram", rd, 16'h7777);
      host_write(2'd2, 16'h0020);
      otg_addr = 2'd0;
      drv = 16'hCCCC;
      drv_en = 1'b1;
      cs_n = 1'b0;
      wr_n = 1'b0;
      tick(3);
      otg_rst_n = 1'b0;
      tick(3);
      otg_rst_n = 1'b1;
      tick(3);
      wr_n = 1'b1;
      cs_n = 1'b1;
      tick(3);
      drv_en = 1'b0;
      host_read(2'd2, rd); check("hrst_ptr", rd, 16'h0000);
      host_read(2'd3, rd); check("hrst_status", rd, 16'h0000);
      host_read(2'd0, rd); check("hrst_no_commit", rd, 16'h2222);
`ifdef HPI_RESPONDER_MAILBOX_EN
      host_write(2'd1, 16'h1234);
      host_write(2'd1, 16'h5678);
      check("rx_data", rx_data, 16'h1234);
      check("rx_valid", {15'b0, rx_valid}, 16'h1);
      host_read(2'd3, rd); check("status_5", rd, 16'h0005);
      host_read(2'd3, rd); check("status_1", rd, 16'h0001);
      rx_ack = 1'b1;
      tick(1);
      rx_ack = 1'b0;
      check("rx_acked", {15'b0, rx_valid}, 16'h0);
      tx_data = 16'hBEEF;
      tx_valid = 1'b1;
      tick(1);
      tx_valid = 1'b0;
      check("int_set", {15'b0, otg_int}, 16'h1);
      check("tx_ready_low", {15'b0, tx_ready}, 16'h0);
      host_read(2'd1, rd); check("mbx_beef", rd, 16'hBEEF);
      check("int_clear", {15'b0, otg_int}, 16'h0);
      check("tx_ready_high", {15'b0, tx_ready}, 16'h1);
`else
      host_read(2'd1, rd); check("mbx_rd_zero", rd, 16'h0000);
      tx_data = 16'hBEEF;
      tx_valid = 1'b1;
      tick(2);
      check("int_tied", {15'b0, otg_int}, 16'h0);
      check("tx_ready_tied", {15'b0, tx_ready}, 16'h0);
      tx_valid = 1'b0;
      host_write(2'd1, 16'h1234);
      check("rx_valid_tied", {15'b0, rx_valid}, 16'h0);
      host_read(2'd3, rd); check("status_zero", rd, 16'h0000);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
